// File: rtl/glip_uart_rx_sampler_pkg.sv
// Shared definitions for the GLIP UART receive path: FSM encodings,
// 8N1 frame constants and the 3-sample majority helper.
package glip_uart_rx_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } rx_state_e;

    localparam int DATA_BITS = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/glip_uart_rx_sampler_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// parameterised reset value so an idle-high line comes out of reset idle.
module glip_uart_rx_sampler_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability chain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/glip_uart_rx_sampler.sv
// 8N1 UART receive front end: majority-voted mid-bit sampling, false-start
// rejection, framing-error and line-break reporting.
module glip_uart_rx_sampler
    import glip_uart_rx_sampler_pkg::*;
#(
    parameter int DIVISOR = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       enable,
    output logic       error,
    output logic       break_det
);

    localparam int CNT_W = $clog2(DIVISOR);
    localparam int HALF  = DIVISOR / 2;
    localparam logic [CNT_W-1:0] CNT_SMP0 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_SMP1 = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    logic             rx_s;
    rx_state_e        state_r;
    rx_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bitidx_r;
    logic [1:0]       smp_r;
    logic [7:0]       data_sr_r;
    logic [7:0]       data_r;
    logic             enable_r;
    logic             error_r;
    logic             break_r;
    logic             at_vote_s;
    logic             at_last_s;
    logic             vote_s;
    logic             en_nxt_s;
    logic             err_nxt_s;
    logic             brk_nxt_s;

    glip_uart_rx_sampler_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign at_vote_s = (cnt_r == CNT_VOTE);
    assign at_last_s = (cnt_r == CNT_LAST);
    // The third sample is the live rx_s at the vote cycle.
    assign vote_s    = majority3(smp_r[0], smp_r[1], rx_s);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) state_nxt_s = ST_START;
                else       state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (at_vote_s && vote_s) state_nxt_s = ST_IDLE;
                else if (at_last_s)      state_nxt_s = ST_DATA;
                else                     state_nxt_s = ST_START;
            end
            ST_DATA: begin
                if (at_last_s && (bitidx_r == BIT_LAST)) state_nxt_s = ST_STOP;
                else                                     state_nxt_s = ST_DATA;
            end
            ST_STOP: begin
                if (at_vote_s) state_nxt_s = vote_s ? ST_IDLE : ST_RECOVER;
                else           state_nxt_s = ST_STOP;
            end
            ST_RECOVER: begin
                if (rx_s) state_nxt_s = ST_IDLE;
                else      state_nxt_s = ST_RECOVER;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output pulse and break-flag decode
    always_comb begin
        en_nxt_s  = 1'b0;
        err_nxt_s = 1'b0;
        brk_nxt_s = break_r;
        case (state_r)
            ST_STOP: begin
                if (at_vote_s && vote_s) begin
                    en_nxt_s = 1'b1;
                end else if (at_vote_s) begin
                    err_nxt_s = 1'b1;
                    brk_nxt_s = (data_sr_r == 8'h00) ? 1'b1 : break_r;
                end else begin
                    en_nxt_s = 1'b0;
                end
            end
            ST_RECOVER: begin
                if (rx_s) brk_nxt_s = 1'b0;
                else      brk_nxt_s = break_r;
            end
            default: brk_nxt_s = break_r;
        endcase
    end

    // Bit timing, sample capture and deserialisation
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            bitidx_r  <= 3'd0;
            smp_r     <= 2'b11;
            data_sr_r <= 8'h00;
        end else begin
            // Entering START from IDLE: the detection cycle already counted as 0.
            if (state_r == ST_IDLE) begin
                cnt_r <= rx_s ? '0 : CNT_W'(1);
            end else if (at_last_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end

            if (cnt_r == CNT_SMP0) begin
                smp_r[0] <= rx_s;
            end else if (cnt_r == CNT_SMP1) begin
                smp_r[1] <= rx_s;
            end else begin
                smp_r <= smp_r;
            end

            if ((state_r == ST_START) && at_last_s) begin
                bitidx_r <= 3'd0;
            end else if ((state_r == ST_DATA) && at_last_s) begin
                bitidx_r <= bitidx_r + 3'd1;
            end else begin
                bitidx_r <= bitidx_r;
            end

            if ((state_r == ST_DATA) && at_vote_s) begin
                data_sr_r <= {vote_s, data_sr_r[7:1]};
            end else begin
                data_sr_r <= data_sr_r;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r   <= 8'h00;
            enable_r <= 1'b0;
            error_r  <= 1'b0;
            break_r  <= 1'b0;
        end else begin
            data_r   <= en_nxt_s ? data_sr_r : data_r;
            enable_r <= en_nxt_s;
            error_r  <= err_nxt_s;
            break_r  <= brk_nxt_s;
        end
    end

    assign data      = data_r;
    assign enable    = enable_r;
    assign error     = error_r;
    assign break_det = break_r;

endmodule

// File: tb/tb_glip_uart_rx_sampler.sv
// Bench for glip_uart_rx_sampler at DIVISOR=16: a per-cycle schedule of expected
// outputs is derived from frame timing and compared against the DUT every cycle.
module tb_glip_uart_rx_sampler;

    localparam int DIV   = 16;
    localparam int HALF  = DIV / 2;
    // rx edge -> cnt-0 cycle is 2 synchroniser cycles, then the documented latency
    localparam int LAT   = 2 + 9 * DIV + HALF + 2;
    localparam int FRAME = 10 * DIV;
    localparam int NCYC  = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       enable;
    logic       error;
    logic       break_det;

    glip_uart_rx_sampler #(.DIVISOR(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .enable    (enable),
        .error     (error),
        .break_det (break_det)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         exp_en  [0:NCYC-1];
    bit         exp_err [0:NCYC-1];
    bit         exp_brk [0:NCYC-1];
    bit         exp_rst [0:NCYC-1];
    logic [7:0] exp_val [0:NCYC-1];

    int         n_vec = 0;
    int         n_bad = 0;
    bit         chk_on = 1'b0;
    logic [7:0] model_data = 8'h00;
    int         en_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    // Per-cycle compare against the expected schedule
    always @(negedge clk) begin
        if (chk_on && cyc < NCYC) begin
            if (exp_rst[cyc]) model_data = 8'h00;
            if (exp_en[cyc])  model_data = exp_val[cyc];
            check("enable",    {7'd0, enable},    {7'd0, exp_en[cyc]});
            check("error",     {7'd0, error},     {7'd0, exp_err[cyc]});
            check("break_det", {7'd0, break_det}, {7'd0, exp_brk[cyc]});
            check("data",      data,              model_data);
            check("en_err_excl", {7'd0, enable & error}, 8'h00);
            if (enable === 1'b1) en_q.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame starting now; schedule the outcome it must produce.
    task automatic send_frame(input logic [7:0] v, input bit stop_hi);
        int c0;
        c0 = cyc;
        if (stop_hi) begin
            exp_en[c0 + LAT]  = 1'b1;
            exp_val[c0 + LAT] = v;
        end else begin
            exp_err[c0 + LAT] = 1'b1;
            if (v == 8'h00)
                for (int k = c0 + LAT; k <= c0 + FRAME + 2; k++) exp_brk[k] = 1'b1;
        end
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            tick(DIV);
        end
        rx = stop_hi;
        tick(DIV);
        rx = 1'b1;
    endtask

    initial begin
        int c0;
        int g;
        int cr;

        // Reset state
        tick(1);
        chk_on = 1'b1;
        check("rst_data",  data, 8'h00);
        check("rst_en",    {7'd0, enable}, 8'h00);
        tick(2);
        rst = 1'b0;
        tick(2 * DIV);

        // 1: clean 0xA5
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        tick(2 * DIV);
        check("t1_pulses", 8'(en_q.size()), 8'd1);
        if (en_q.size() > 0) check("t1_latency", 8'(en_q[0] - c0), 8'd156);
        check("t1_data", data, 8'hA5);

        // 2: 3-cycle glitch, then a frame timed to be caught right at cnt 10
        g = cyc;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(7);
        check("t2_align", 8'(cyc - g), 8'd10);
        send_frame(8'hC3, 1'b1);
        tick(2 * DIV);
        check("t2_pulses", 8'(en_q.size()), 8'd2);
        check("t2_data", data, 8'hC3);

        // 3: 0x3C with low stop bit
        send_frame(8'h3C, 1'b0);
        tick(2 * DIV);
        check("t3_data_kept", data, 8'hC3);
        check("t3_no_break", {7'd0, break_det}, 8'h00);

        // 4: line held low for 20 bit times
        c0 = cyc;
        exp_err[c0 + LAT] = 1'b1;
        cr = c0 + 20 * DIV;
        for (int k = c0 + LAT; k <= cr + 2; k++) exp_brk[k] = 1'b1;
        rx = 1'b0;
        tick(20 * DIV);
        rx = 1'b1;
        tick(2);
        check("t4_brk_hold", {7'd0, break_det}, 8'h01);
        tick(1);
        check("t4_brk_clear", {7'd0, break_det}, 8'h00);
        tick(2 * DIV);
        check("t4_no_enable", 8'(en_q.size()), 8'd2);

        // 5: back-to-back 0x00, 0xFF, 0x55
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        tick(2 * DIV);
        check("t5_pulses", 8'(en_q.size()), 8'd5);
        if (en_q.size() == 5) begin
            check("t5_gap1", 8'(en_q[3] - en_q[2]), 8'd160);
            check("t5_gap2", 8'(en_q[4] - en_q[3]), 8'd160);
        end
        check("t5_data", data, 8'h55);

        // 6: reset during data bit 4 of 0x81, then 0x42
        c0 = cyc;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            tick(DIV);
        end
        rx = 1'b0;
        tick(HALF);
        exp_rst[c0 + 5 * DIV + HALF + 1] = 1'b1;
        rst = 1'b1;
        rx  = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_data",  data, 8'h00);
        check("t6_rst_en",    {7'd0, enable}, 8'h00);
        check("t6_rst_err",   {7'd0, error}, 8'h00);
        check("t6_rst_brk",   {7'd0, break_det}, 8'h00);
        tick(3 * DIV);
        send_frame(8'h42, 1'b1);
        tick(2 * DIV);
        check("t6_pulses", 8'(en_q.size()), 8'd6);
        check("t6_data", data, 8'h42);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
